fwd_network: RTL and testbench
==============================

Name: fwd_network

Overview:
Parametrised result-forwarding network for the dual-issue SIMD core, generalised to NUM_PIPES pipes of DEPTH result stages each. Each pipe keeps a valid-tagged shift register of in-flight results (valid, destination address, quadword). Execution units inject results at the stage where they complete. Every operand read in register fetch is matched against all live entries, youngest first, with cross-pipe forwarding, and the network supplies a registered forwarded operand plus a hit flag. Adds stall, flush, and a per-pipe writeback port to the register file.

Parameters:
NUM_PIPES, 2, number of issue pipes (0 = even, 1 = odd)
DEPTH, 7, result stages per pipe; stage 0 youngest, stage DEPTH-1 = writeback
NUM_SRC, 3, operand read ports per pipe (ra, rb, rc)
AW, 7, register address width
DW, 128, data width (quadword)
FLUSH_STAGES, 3, number of youngest stages cleared by flush (1..DEPTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  freeze all state
flush  in  1  kill non-committed results
inj_valid  in  NUM_PIPES*DEPTH  result injection valid, index p*DEPTH+s
inj_addr  in  NUM_PIPES*DEPTH*AW  injected destination address
inj_data  in  NUM_PIPES*DEPTH*DW  injected result
rd_addr  in  NUM_PIPES*NUM_SRC*AW  fetch operand addresses, index p*NUM_SRC+k
rf_data  in  NUM_PIPES*NUM_SRC*DW  register file read data for the same operands
fwd_data  out  NUM_PIPES*NUM_SRC*DW  resolved operand, registered
fwd_hit  out  NUM_PIPES*NUM_SRC  1 = operand came from the network, registered
wb_valid  out  NUM_PIPES  stage DEPTH-1 entry valid
wb_addr  out  NUM_PIPES*AW  stage DEPTH-1 destination
wb_data  out  NUM_PIPES*DW  stage DEPTH-1 result

Behaviour:
- Reset: all entry valids 0, addr/data 0; fwd_data, fwd_hit, wb_* all 0.
- Stage update (no stall, no flush): entry[p][s] <= inj_valid[p][s] ? inject : entry[p][s-1]. For stage 0 the second term is an invalid entry. Injection overrides the shifted-in entry, and the overridden entry is dropped. This is the single-writer-per-stage rule; units share an injection slot only if the issue logic guarantees they are exclusive.
- Injection with inj_valid=0 never creates a valid entry. An address of 0 is treated as an ordinary register.
- Lookup is combinational on rd_addr vs. current entries, and the result is registered, so latency is 1 cycle.
- Match condition: entry valid and entry addr == rd_addr.
- Priority: the lowest stage index wins. Within the same stage, the reading pipe's own entry wins, then other pipes in ascending order starting at (p+1) mod NUM_PIPES.
- No match: fwd_data = rf_data, fwd_hit = 0.
- wb_* are the stage DEPTH-1 entry, driven directly from the register with no extra latency. Stage DEPTH-1 also takes part in lookup, which covers a register file write and read in the same cycle.
- Stall=1: entries, fwd_*, and counters hold; injections that cycle are ignored.
- Flush=1: valid cleared for stages 0..FLUSH_STAGES-1 on the next edge, while older stages shift normally.
  - Injections into flushed stages are discarded.
  - Entries shifting out of stage FLUSH_STAGES-1 into stage FLUSH_STAGES are also discarded.
  - fwd_* update normally from pre-flush entries.
- Flush has priority over stall: a flush during a stall still clears, and older stages hold.
- Reset has priority over everything and may occur mid-flight; all in-flight results are lost.

Optional Feature:
FWD_HIT_COUNTERS_EN:
- Defined: adds output hit_count (NUM_PIPES*32). Each pipe's counter increments by the number of its operands with a hit in that cycle, counting only non-stalled cycles. Counters saturate at 2^32-1 and reset to 0.
- Undefined: the port and logic are absent, and other behaviour is identical.

Decomposition:
- Shared package fwd_pkg holds fwd_entry_t (valid, addr[AW], data[DW]) and the default constants AW=7, DW=128, DEPTH=7, NUM_PIPES=2.
- One sub-module, fwd_select: given a read address and a flattened entry array in priority order, it returns hit and data. It is instantiated NUM_PIPES*NUM_SRC times, and the top level only reorders entries per reading pipe.

Test Plan:
- Inject pipe0 stage0 addr 5 data A, then read addr 5 on pipe1 rb the next cycle -> one cycle later fwd_hit=1, fwd_data=A; after DEPTH-1 more cycles wb_valid[0]=1, wb_addr=5.
- Pipe0 stage2 addr 9 = B and pipe1 stage2 addr 9 = C in flight, pipe1 reads 9 -> C (own pipe wins); then inject pipe0 stage1 addr 9 = D, read -> D (younger wins).
- Read addr 12 with no entry, rf_data = 0xDEAD… -> fwd_hit=0, fwd_data=0xDEAD….
- Entries at stages 1 and 4 with flush=1, FLUSH_STAGES=3 -> the stage-1 entry vanishes, and the stage-4 entry reaches wb after 2 more cycles.
- Stall held 3 cycles with inj_valid asserted -> no entry moves, injections lost, fwd_* unchanged; release resumes shifting.
- Reset asserted while 4 entries are live -> next cycle all fwd_hit=0 and wb_valid=0, and a read of a previously live address returns rf_data.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and default sizes for the result-forwarding network.
// Holds the entry payload (valid, destination address, quadword) and the
// default configuration constants used by fwd_network and its testbench.
package fwd_pkg;

    localparam int unsigned FWD_AW           = 7;
    localparam int unsigned FWD_DW           = 128;
    localparam int unsigned FWD_DEPTH        = 7;
    localparam int unsigned FWD_NUM_PIPES    = 2;
    localparam int unsigned FWD_NUM_SRC      = 3;
    localparam int unsigned FWD_FLUSH_STAGES = 3;
    localparam int unsigned FWD_CNT_W        = 32;

    typedef struct packed {
        logic                valid;
        logic [FWD_AW-1:0]   addr;
        logic [FWD_DW-1:0]   data;
    } fwd_entry_t;

endpackage

// File: rtl/fwd_select.sv
// Priority match of one operand address against a flattened entry list.
// Entry 0 has the highest priority; the caller orders the list.
// Ports:
//   i_rd_addr  operand address
//   i_valid    per-entry valid, N bits
//   i_addr     per-entry destination address, N*AW bits
//   i_data     per-entry result, N*DW bits
//   i_rf_data  register file fallback value
//   o_hit_c    1 = some entry matched (combinational)
//   o_data_c   matched entry data, else i_rf_data (combinational)
module fwd_select #(
    parameter int unsigned N  = 14,
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 128
) (
    input  logic [AW-1:0]   i_rd_addr,
    input  logic [N-1:0]    i_valid,
    input  logic [N*AW-1:0] i_addr,
    input  logic [N*DW-1:0] i_data,
    input  logic [DW-1:0]   i_rf_data,
    output logic            o_hit_c,
    output logic [DW-1:0]   o_data_c
);

    // Scan from lowest to highest priority so the last match written wins.
    always_comb begin
        o_hit_c  = 1'b0;
        o_data_c = i_rf_data;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (i_valid[i] && (i_addr[i*AW +: AW] == i_rd_addr)) begin
                o_hit_c  = 1'b1;
                o_data_c = i_data[i*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/fwd_network.sv
// Result-forwarding network: NUM_PIPES shift registers of DEPTH result
// stages, operand lookup with cross-pipe forwarding, stall/flush and a
// per-pipe writeback view of the oldest stage.
// Optional feature macro: FWD_HIT_COUNTERS_EN adds o_hit_count.
// Ports (flattened, pipe-major):
//   clk, reset     clock, synchronous active-high reset
//   i_stall        freeze entries and forwarded operands
//   i_flush        clear stages 0..FLUSH_STAGES-1
//   i_inj_*        result injection, index p*DEPTH+s
//   i_rd_addr      operand addresses, index p*NUM_SRC+k
//   i_rf_data      register file data for the same operands
//   o_fwd_data/hit registered resolved operand and hit flag
//   o_wb_*         stage DEPTH-1 entry per pipe
//   o_hit_count    per-pipe saturating 32-bit hit counters (optional)
module fwd_network
    import fwd_pkg::*;
#(
    parameter int unsigned NUM_PIPES    = FWD_NUM_PIPES,
    parameter int unsigned DEPTH        = FWD_DEPTH,
    parameter int unsigned NUM_SRC      = FWD_NUM_SRC,
    parameter int unsigned AW           = FWD_AW,
    parameter int unsigned DW           = FWD_DW,
    parameter int unsigned FLUSH_STAGES = FWD_FLUSH_STAGES
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_stall,
    input  logic                            i_flush,
    input  logic [NUM_PIPES*DEPTH-1:0]      i_inj_valid,
    input  logic [NUM_PIPES*DEPTH*AW-1:0]   i_inj_addr,
    input  logic [NUM_PIPES*DEPTH*DW-1:0]   i_inj_data,
    input  logic [NUM_PIPES*NUM_SRC*AW-1:0] i_rd_addr,
    input  logic [NUM_PIPES*NUM_SRC*DW-1:0] i_rf_data,
    output logic [NUM_PIPES*NUM_SRC*DW-1:0] o_fwd_data,
    output logic [NUM_PIPES*NUM_SRC-1:0]    o_fwd_hit,
    output logic [NUM_PIPES-1:0]            o_wb_valid,
    output logic [NUM_PIPES*AW-1:0]         o_wb_addr,
    output logic [NUM_PIPES*DW-1:0]         o_wb_data
`ifdef FWD_HIT_COUNTERS_EN
    ,
    output logic [NUM_PIPES*FWD_CNT_W-1:0]  o_hit_count
`endif
);

    localparam int unsigned NE = NUM_PIPES * DEPTH;
    localparam int unsigned NR = NUM_PIPES * NUM_SRC;

    logic [NE-1:0]                       r_valid;
    logic [NE-1:0][AW-1:0]               r_addr;
    logic [NE-1:0][DW-1:0]               r_data;
    logic [NE-1:0]                       w_valid_nxt;
    logic [NE-1:0][AW-1:0]               w_addr_nxt;
    logic [NE-1:0][DW-1:0]               w_data_nxt;

    logic [NUM_PIPES-1:0][NE-1:0]         w_ord_valid;
    logic [NUM_PIPES-1:0][NE-1:0][AW-1:0] w_ord_addr;
    logic [NUM_PIPES-1:0][NE-1:0][DW-1:0] w_ord_data;

    logic [NR-1:0]                       w_hit;
    logic [NR-1:0][DW-1:0]               w_sel_data;
    logic [NR-1:0]                       r_fwd_hit;
    logic [NR-1:0][DW-1:0]               r_fwd_data;

    // Stage next-state: flush clears young stages regardless of stall;
    // the stage just past the flush window refuses the flushed shift-in.
    always_comb begin
        w_valid_nxt = r_valid;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        for (int unsigned p = 0; p < NUM_PIPES; p++) begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                if (i_flush && (s < FLUSH_STAGES)) begin
                    w_valid_nxt[p*DEPTH+s] = 1'b0;
                end else if (!i_stall) begin
                    if (i_inj_valid[p*DEPTH+s]) begin
                        w_valid_nxt[p*DEPTH+s] = 1'b1;
                        w_addr_nxt[p*DEPTH+s]  = i_inj_addr[(p*DEPTH+s)*AW +: AW];
                        w_data_nxt[p*DEPTH+s]  = i_inj_data[(p*DEPTH+s)*DW +: DW];
                    end else if ((s == 0) || (i_flush && (s == FLUSH_STAGES))) begin
                        w_valid_nxt[p*DEPTH+s] = 1'b0;
                    end else begin
                        w_valid_nxt[p*DEPTH+s] = r_valid[p*DEPTH+s-1];
                        w_addr_nxt[p*DEPTH+s]  = r_addr[p*DEPTH+s-1];
                        w_data_nxt[p*DEPTH+s]  = r_data[p*DEPTH+s-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Per reading pipe: stage-major order, own pipe first, then (p+j) mod N.
    always_comb begin
        w_ord_valid = '0;
        w_ord_addr  = '0;
        w_ord_data  = '0;
        for (int unsigned p = 0; p < NUM_PIPES; p++) begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                for (int unsigned j = 0; j < NUM_PIPES; j++) begin
                    w_ord_valid[p][s*NUM_PIPES+j] = r_valid[((p+j)%NUM_PIPES)*DEPTH+s];
                    w_ord_addr[p][s*NUM_PIPES+j]  = r_addr[((p+j)%NUM_PIPES)*DEPTH+s];
                    w_ord_data[p][s*NUM_PIPES+j]  = r_data[((p+j)%NUM_PIPES)*DEPTH+s];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
        for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
            fwd_select #(
                .N  (NE),
                .AW (AW),
                .DW (DW)
            ) u_sel (
                .i_rd_addr (i_rd_addr[(p*NUM_SRC+k)*AW +: AW]),
                .i_valid   (w_ord_valid[p]),
                .i_addr    (w_ord_addr[p]),
                .i_data    (w_ord_data[p]),
                .i_rf_data (i_rf_data[(p*NUM_SRC+k)*DW +: DW]),
                .o_hit_c   (w_hit[p*NUM_SRC+k]),
                .o_data_c  (w_sel_data[p*NUM_SRC+k])
            );
        end
        assign o_wb_valid[p]          = r_valid[p*DEPTH+DEPTH-1];
        assign o_wb_addr[p*AW +: AW]  = r_addr[p*DEPTH+DEPTH-1];
        assign o_wb_data[p*DW +: DW]  = r_data[p*DEPTH+DEPTH-1];
    end

    // Forwarded operands update from pre-flush entries; hold on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fwd_hit  <= '0;
            r_fwd_data <= '0;
        end else if (!i_stall) begin
            r_fwd_hit  <= w_hit;
            r_fwd_data <= w_sel_data;
        end
    end

    assign o_fwd_hit  = r_fwd_hit;
    assign o_fwd_data = r_fwd_data;

`ifdef FWD_HIT_COUNTERS_EN
    logic [NUM_PIPES-1:0][FWD_CNT_W-1:0] r_hit_cnt;
    logic [NUM_PIPES-1:0][FWD_CNT_W-1:0] w_cnt_nxt;

    // One extra sum bit flags overflow so the counter sticks at all-ones.
    always_comb begin
        logic [FWD_CNT_W:0] v_sum;
        v_sum     = '0;
        w_cnt_nxt = r_hit_cnt;
        for (int unsigned p = 0; p < NUM_PIPES; p++) begin
            v_sum = {1'b0, r_hit_cnt[p]};
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                v_sum = v_sum + (FWD_CNT_W+1)'(w_hit[p*NUM_SRC+k]);
            end
            w_cnt_nxt[p] = v_sum[FWD_CNT_W] ? '1 : v_sum[FWD_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_cnt <= '0;
        end else if (!i_stall) begin
            r_hit_cnt <= w_cnt_nxt;
        end
    end

    assign o_hit_count = r_hit_cnt;
`endif

endmodule

// File: tb/tb_fwd_network.sv
// Directed self-checking bench for fwd_network with default parameters.
module tb_fwd_network;
    import fwd_pkg::*;

    localparam int unsigned NP = FWD_NUM_PIPES;
    localparam int unsigned DP = FWD_DEPTH;
    localparam int unsigned NS = FWD_NUM_SRC;
    localparam int unsigned AW = FWD_AW;
    localparam int unsigned DW = FWD_DW;

    localparam logic [DW-1:0] DA  = {4{32'hAAAA_0001}};
    localparam logic [DW-1:0] DB  = {4{32'hBBBB_0002}};
    localparam logic [DW-1:0] DC  = {4{32'hCCCC_0003}};
    localparam logic [DW-1:0] DD  = {4{32'hDDDD_0004}};
    localparam logic [DW-1:0] DE  = {4{32'hEEEE_0005}};
    localparam logic [DW-1:0] DF  = {4{32'hF0F0_0006}};
    localparam logic [DW-1:0] DG  = {4{32'h1234_0007}};
    localparam logic [DW-1:0] DI  = {4{32'h5555_0008}};
    localparam logic [DW-1:0] DJ  = {4{32'h6666_0009}};
    localparam logic [DW-1:0] DR  = {4{32'h0BAD_F00D}};
    localparam logic [DW-1:0] DZ  = {4{32'h7777_777A}};
    localparam logic [DW-1:0] DX  = {4{32'hDEAD_BEEF}};

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     stall;
    logic                     flush;
    logic [NP*DP-1:0]         inj_valid;
    logic [NP*DP*AW-1:0]      inj_addr;
    logic [NP*DP*DW-1:0]      inj_data;
    logic [NP*NS*AW-1:0]      rd_addr;
    logic [NP*NS*DW-1:0]      rf_data;
    logic [NP*NS*DW-1:0]      fwd_data;
    logic [NP*NS-1:0]         fwd_hit;
    logic [NP-1:0]            wb_valid;
    logic [NP*AW-1:0]         wb_addr;
    logic [NP*DW-1:0]         wb_data;
`ifdef FWD_HIT_COUNTERS_EN
    logic [NP*FWD_CNT_W-1:0]  hit_count;
`endif

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    fwd_network dut (
        .clk         (clk),
        .reset       (reset),
        .i_stall     (stall),
        .i_flush     (flush),
        .i_inj_valid (inj_valid),
        .i_inj_addr  (inj_addr),
        .i_inj_data  (inj_data),
        .i_rd_addr   (rd_addr),
        .i_rf_data   (rf_data),
        .o_fwd_data  (fwd_data),
        .o_fwd_hit   (fwd_hit),
        .o_wb_valid  (wb_valid),
        .o_wb_addr   (wb_addr),
        .o_wb_data   (wb_data)
`ifdef FWD_HIT_COUNTERS_EN
        ,
        .o_hit_count (hit_count)
`endif
    );

    typedef struct {
        logic          iv0;
        int            ip0;
        int            is0;
        logic [AW-1:0] ia0;
        logic [DW-1:0] id0;
        logic          iv1;
        int            ip1;
        int            is1;
        logic [AW-1:0] ia1;
        logic [DW-1:0] id1;
        int            rp;
        int            rk;
        logic [AW-1:0] ra;
        logic [DW-1:0] rf;
        logic          eh;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        stall     = 1'b0;
        flush     = 1'b0;
        inj_valid = '0;
        inj_addr  = '0;
        inj_data  = '0;
        rd_addr   = '0;
        rf_data   = '0;
    endtask

    task automatic do_reset();
        clr_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic inj(input logic v, input int p, input int s, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
        inj_valid[p*DP+s]           = v;
        inj_addr[(p*DP+s)*AW +: AW] = a;
        inj_data[(p*DP+s)*DW +: DW] = d;
    endtask

    task automatic rd(input int p, input int k, input logic [AW-1:0] a, input logic [DW-1:0] rf);
        rd_addr[(p*NS+k)*AW +: AW] = a;
        rf_data[(p*NS+k)*DW +: DW] = rf;
    endtask

    function automatic logic [DW-1:0] fdat(input int p, input int k);
        return fwd_data[(p*NS+k)*DW +: DW];
    endfunction

    function automatic logic fhit(input int p, input int k);
        return fwd_hit[p*NS+k];
    endfunction

    initial begin
        reset = 1'b1;
        clr_in();

        vecs[0] = '{1'b1, 0, 0, 7'd5,  DA, 1'b0, 0, 0, 7'd0,  '0, 1, 1, 7'd5,  DR, 1'b1, DA};
        vecs[1] = '{1'b1, 0, 2, 7'd9,  DB, 1'b1, 1, 2, 7'd9,  DC, 1, 0, 7'd9,  DR, 1'b1, DC};
        vecs[2] = '{1'b1, 0, 2, 7'd9,  DB, 1'b1, 1, 2, 7'd9,  DC, 0, 2, 7'd9,  DR, 1'b1, DB};
        vecs[3] = '{1'b1, 0, 1, 7'd9,  DD, 1'b1, 1, 3, 7'd9,  DC, 1, 0, 7'd9,  DR, 1'b1, DD};
        vecs[4] = '{1'b0, 0, 0, 7'd0,  '0, 1'b0, 0, 0, 7'd0,  '0, 0, 1, 7'd12, DX, 1'b0, DX};
        vecs[5] = '{1'b1, 1, 6, 7'd0,  DE, 1'b0, 0, 0, 7'd0,  '0, 0, 0, 7'd0,  DR, 1'b1, DE};
        vecs[6] = '{1'b0, 0, 0, 7'd7,  DF, 1'b0, 0, 0, 7'd0,  '0, 0, 0, 7'd7,  DR, 1'b0, DR};
        vecs[7] = '{1'b1, 0, 3, 7'd20, DF, 1'b1, 1, 5, 7'd21, DG, 0, 1, 7'd21, DR, 1'b1, DG};
        vecs[8] = '{1'b1, 1, 4, 7'd3,  DI, 1'b1, 0, 4, 7'd3,  DJ, 1, 2, 7'd3,  DR, 1'b1, DI};
        vecs[9] = '{1'b1, 1, 4, 7'd3,  DI, 1'b1, 0, 4, 7'd3,  DJ, 0, 2, 7'd3,  DR, 1'b1, DJ};

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk("rst_fwd_hit",  DW'(fwd_hit),  '0);
        chk("rst_fwd_data", fwd_data[DW-1:0], '0);
        chk("rst_wb_valid", DW'(wb_valid), '0);
        chk("rst_wb_data",  wb_data[DW-1:0], '0);
`ifdef FWD_HIT_COUNTERS_EN
        chk("rst_hit_count", DW'(hit_count), '0);
`endif

        // Table: inject, then read the following cycle
        for (int i = 0; i < 10; i++) begin
            do_reset();
            inj(vecs[i].iv0, vecs[i].ip0, vecs[i].is0, vecs[i].ia0, vecs[i].id0);
            if (vecs[i].iv1) inj(1'b1, vecs[i].ip1, vecs[i].is1, vecs[i].ia1, vecs[i].id1);
            tick();
            clr_in();
            rd(vecs[i].rp, vecs[i].rk, vecs[i].ra, vecs[i].rf);
            tick();
            chk($sformatf("vec%0d_hit", i), DW'(fhit(vecs[i].rp, vecs[i].rk)), DW'(vecs[i].eh));
            chk($sformatf("vec%0d_data", i), fdat(vecs[i].rp, vecs[i].rk), vecs[i].ed);
        end

        // Inject -> cross-pipe read -> writeback after DEPTH-1 more cycles
        do_reset();
        inj(1'b1, 0, 0, 7'd5, DA);
        tick();
        clr_in();
        rd(1, 1, 7'd5, DR);
        tick();
        chk("wbseq_hit", DW'(fhit(1, 1)), 1);
        chk("wbseq_data", fdat(1, 1), DA);
        clr_in();
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("wbseq_valid_t%0d", i), DW'(wb_valid[0]), DW'(i == 5));
        end
        chk("wbseq_addr", DW'(wb_addr[AW-1:0]), 5);
        chk("wbseq_wdata", wb_data[DW-1:0], DA);

        // Flush: young stages cleared, older stage continues to writeback
        do_reset();
        inj(1'b1, 0, 1, 7'd30, DB);
        inj(1'b1, 0, 4, 7'd31, DC);
        inj(1'b1, 1, 2, 7'd40, DD);
        tick();
        clr_in();
        flush = 1'b1;
        inj(1'b1, 1, 0, 7'd41, DE);
        rd(0, 0, 7'd30, DR);
        tick();
        chk("flush_pre_hit", DW'(fhit(0, 0)), 1);
        chk("flush_pre_data", fdat(0, 0), DB);
        chk("flush_wb_early", DW'(wb_valid[0]), 0);
        clr_in();
        rd(0, 0, 7'd30, DR);
        rd(1, 0, 7'd40, DR);
        rd(1, 1, 7'd41, DR);
        rd(0, 1, 7'd31, DR);
        tick();
        chk("flush_gone_hit", DW'(fhit(0, 0)), 0);
        chk("flush_gone_data", fdat(0, 0), DR);
        chk("flush_shiftout_hit", DW'(fhit(1, 0)), 0);
        chk("flush_inj_hit", DW'(fhit(1, 1)), 0);
        chk("flush_old_data", fdat(0, 1), DC);
        chk("flush_wb_valid", DW'(wb_valid[0]), 1);
        chk("flush_wb_addr", DW'(wb_addr[AW-1:0]), 31);

        // Stall: hold for 3 cycles, injections lost, then resume
        do_reset();
        inj(1'b1, 0, 0, 7'd50, DF);
        tick();
        clr_in();
        rd(0, 0, 7'd50, DR);
        tick();
        chk("stall_pre_data", fdat(0, 0), DF);
        for (int c = 0; c < 3; c++) begin
            clr_in();
            stall = 1'b1;
            inj(1'b1, 1, 0, 7'd51, DG);
            rd(0, 0, 7'd51, DZ);
            tick();
            chk($sformatf("stall_hold_hit%0d", c), DW'(fhit(0, 0)), 1);
            chk($sformatf("stall_hold_data%0d", c), fdat(0, 0), DF);
        end
        clr_in();
        rd(0, 0, 7'd51, DZ);
        rd(0, 1, 7'd50, DR);
        tick();
        chk("stall_lost_hit", DW'(fhit(0, 0)), 0);
        chk("stall_lost_data", fdat(0, 0), DZ);
        chk("stall_kept_data", fdat(0, 1), DF);
        clr_in();
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("stall_wb_t%0d", i), DW'(wb_valid[0]), DW'(i == 4));
        end

        // Reset with 4 live entries
        do_reset();
        inj(1'b1, 0, 0, 7'd60, DA);
        inj(1'b1, 1, 1, 7'd61, DB);
        inj(1'b1, 0, 6, 7'd62, DC);
        inj(1'b1, 1, 3, 7'd63, DD);
        tick();
        clr_in();
        reset = 1'b1;
        rd(0, 0, 7'd60, DR);
        rd(1, 0, 7'd61, DR);
        tick();
        chk("midrst_fwd_hit", DW'(fwd_hit), 0);
        chk("midrst_wb_valid", DW'(wb_valid), 0);
        reset = 1'b0;
        tick();
        chk("midrst_read0_hit", DW'(fhit(0, 0)), 0);
        chk("midrst_read0_data", fdat(0, 0), DR);
        chk("midrst_read1_data", fdat(1, 0), DR);

        // Injection overrides the entry shifting into the same stage
        do_reset();
        inj(1'b1, 0, 0, 7'd70, DI);
        tick();
        clr_in();
        inj(1'b1, 0, 1, 7'd71, DJ);
        tick();
        clr_in();
        rd(0, 0, 7'd70, DR);
        rd(0, 1, 7'd71, DR);
        tick();
        chk("ovr_dropped_hit", DW'(fhit(0, 0)), 0);
        chk("ovr_new_data", fdat(0, 1), DJ);
`ifdef FWD_HIT_COUNTERS_EN
        chk("cnt_pipe0", DW'(hit_count[FWD_CNT_W-1:0]), 1);
        chk("cnt_pipe1", DW'(hit_count[2*FWD_CNT_W-1:FWD_CNT_W]), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
